// File: rtl/cg_iteration_sequencer.sv
// Phase scheduler for one conjugate-gradient iteration on the shared ALU:
// MATVEC, DOT_PAP, UPD_XR, DOT_RR, UPD_P, with a convergence/iteration-cap check after each r.r dot.
module cg_iteration_sequencer #(
  parameter int no_of_units    = 8,
  parameter int element_width  = 32,
  parameter int iter_width     = 11,
  parameter int max_iterations = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              total,
  input  logic [element_width-1:0] tolerance,
  input  logic [element_width-1:0] rs_new,
  input  logic                     op_done,
  output logic                     op_start,
  output logic [2:0]               op_sel,
  output logic [31:0]              num_blocks,
  output logic                     busy,
  output logic                     halt,
  output logic                     finish_all,
  output logic                     finish_alu,
  output logic                     converged,
  output logic                     len_error,
  output logic [iter_width-1:0]    iteration_counter,
  output logic [2:0]               state_dbg
);

  // ALU handshake: op_start is a one-cycle launch pulse; op_sel is held from launch until the
  // matching op_done; op_done is honoured only in S_WAIT, and abort beats a same-cycle op_done.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] PH_MATVEC = 3'd0;
  localparam logic [2:0] PH_DOT_RR = 3'd3;
  localparam logic [2:0] PH_UPD_P  = 3'd4;

  localparam logic [iter_width-1:0] last_iter = iter_width'(max_iterations - 1);

  state_t                   state;
  logic [2:0]               phase;
  logic [element_width-1:0] tol_q;
  logic [element_width-1:0] rs_q;
  logic [31:0]              blocks_calc;
  logic [iter_width-1:0]    iter_next;

  assign blocks_calc = total / 32'(no_of_units);
  // The counter saturates rather than wrapping back to zero.
  assign iter_next   = (iteration_counter == {iter_width{1'b1}}) ? iteration_counter
                                                                 : iteration_counter + iter_width'(1);
  assign op_sel      = phase;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      phase             <= PH_MATVEC;
      tol_q             <= '0;
      rs_q              <= '0;
      num_blocks        <= '0;
      op_start          <= 1'b0;
      busy              <= 1'b0;
      halt              <= 1'b0;
      finish_all        <= 1'b0;
      finish_alu        <= 1'b0;
      converged         <= 1'b0;
      len_error         <= 1'b0;
      iteration_counter <= '0;
    end else begin
      op_start   <= 1'b0;
      finish_all <= 1'b0;
      finish_alu <= 1'b0;
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        halt       <= 1'b0;
        finish_alu <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              num_blocks        <= blocks_calc;
              tol_q             <= tolerance;
              iteration_counter <= '0;
              converged         <= 1'b0;
              len_error         <= 1'b0;
              phase             <= PH_MATVEC;
              if (blocks_calc == '0) begin
                state      <= S_DONE;
                busy       <= 1'b0;
                halt       <= 1'b1;
                finish_all <= 1'b1;
                len_error  <= 1'b1;
              end else begin
                state    <= S_ISSUE;
                busy     <= 1'b1;
                halt     <= 1'b0;
                op_start <= 1'b1;
              end
            end
          end
          S_ISSUE: state <= S_WAIT;
          S_WAIT: begin
            if (op_done) begin
              case (phase)
                PH_UPD_P: begin
                  iteration_counter <= iter_next;
                  finish_alu        <= 1'b1;
                  phase             <= PH_MATVEC;
                  state             <= S_ISSUE;
                  op_start          <= 1'b1;
                end
                PH_DOT_RR: begin
                  rs_q  <= rs_new;
                  state <= S_CHECK;
                end
                default: begin
                  phase    <= phase + 3'd1;
                  state    <= S_ISSUE;
                  op_start <= 1'b1;
                end
              endcase
            end
          end
          S_CHECK: begin
            // Non-negative IEEE-754 singles order the same way as their raw bit patterns.
            if (rs_q < tol_q) begin
              converged         <= 1'b1;
              iteration_counter <= iter_next;
              state             <= S_DONE;
              busy              <= 1'b0;
              halt              <= 1'b1;
              finish_all        <= 1'b1;
            end else if (iteration_counter == last_iter) begin
              iteration_counter <= iter_next;
              state             <= S_DONE;
              busy              <= 1'b0;
              halt              <= 1'b1;
              finish_all        <= 1'b1;
            end else begin
              phase    <= PH_UPD_P;
              state    <= S_ISSUE;
              op_start <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            halt  <= 1'b0;
          end
        endcase
      end
    end
  end

  op_start_only_when_busy: assert property (@(posedge clk) disable iff (!reset) op_start |-> busy);
  busy_halt_exclusive:     assert property (@(posedge clk) disable iff (!reset) !(busy && halt));
  finish_all_in_done:      assert property (@(posedge clk) disable iff (!reset) finish_all |-> halt);
  op_sel_held_in_wait:     assert property (@(posedge clk) disable iff (!reset)
                                            (state == S_WAIT && !op_done && !abort) |=> $stable(op_sel));

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Scoreboard bench for cg_iteration_sequencer: a behavioural ALU answers every launch, and a
// solve-level model predicts the op stream and the final result of each solve.
module tb_cg_iteration_sequencer;

  localparam int UNITS  = 8;
  localparam int MAX_IT = 4;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] total;
  logic [31:0] tolerance;
  logic [31:0] rs_new;
  logic        op_done;
  logic        op_start;
  logic [2:0]  op_sel;
  logic [31:0] num_blocks;
  logic        busy;
  logic        halt;
  logic        finish_all;
  logic        finish_alu;
  logic        converged;
  logic        len_error;
  logic [10:0] iteration_counter;
  logic [2:0]  state_dbg;

  typedef struct packed {
    logic        conv;
    logic        len;
    logic [10:0] iters;
    logic [31:0] nb;
  } res_t;

  logic [2:0]  exp_q[$];
  res_t        res_q[$];
  logic [31:0] rs_stim[$];
  logic [31:0] plan[MAX_IT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc     = -100;
  int last_fire_cyc = -100;
  int last_rr_cyc   = -100;
  logic [2:0] last_fire_sel = 3'd0;
  int fire_idx   = 0;
  int abort_at   = -1;
  int lat_max    = 2;
  bit spurious   = 1'b0;
  int fa_aligned = 0;
  int fa_abort   = 0;
  int exp_upd    = 0;

  cg_iteration_sequencer #(
    .no_of_units(UNITS), .element_width(32), .iter_width(11), .max_iterations(MAX_IT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
    .tolerance(tolerance), .rs_new(rs_new), .op_done(op_done), .op_start(op_start),
    .op_sel(op_sel), .num_blocks(num_blocks), .busy(busy), .halt(halt),
    .finish_all(finish_all), .finish_alu(finish_alu), .converged(converged),
    .len_error(len_error), .iteration_counter(iteration_counter), .state_dbg(state_dbg)
  );

  // Clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Solve-level reference: op stream and final result from the iteration rules.
  task automatic plan_solve(input logic [31:0] t, input logic [31:0] tol);
    res_t r;
    r.conv  = 1'b0;
    r.len   = 1'b0;
    r.iters = 11'd0;
    r.nb    = t / UNITS;
    exp_upd = 0;
    rs_stim.delete();
    if (r.nb == 32'd0) r.len = 1'b1;
    else begin
      for (int k = 0; k < MAX_IT; k++) begin
        for (int p = 0; p < 4; p++) exp_q.push_back(3'(p));
        rs_stim.push_back(plan[k]);
        if (plan[k] < tol) begin
          r.conv  = 1'b1;
          r.iters = 11'(k + 1);
          break;
        end
        if (k == MAX_IT - 1) begin
          r.iters = 11'(MAX_IT);
          break;
        end
        exp_q.push_back(3'd4);
        exp_upd++;
      end
    end
    res_q.push_back(r);
  endtask

  task automatic launch(input logic [31:0] t, input logic [31:0] tol);
    @(negedge clk);
    total     = t;
    tolerance = tol;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input bit noisy);
    int i;
    for (i = 0; i < BUDGET; i++) begin
      if (halt) break;
      start = noisy && busy && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    if (i == BUDGET) begin
      n_tests++;
      n_fail++;
      $display("FAIL halt_timeout: halt still 0 after %0d cycles, expected 1", BUDGET);
    end
  endtask

  task automatic run_solve(input logic [31:0] t, input logic [31:0] tol, input bit noisy);
    int fa0;
    int fab0;
    fa0  = fa_aligned;
    fab0 = fa_abort;
    plan_solve(t, tol);
    launch(t, tol);
    wait_halt(noisy);
    repeat (3) @(negedge clk);
    check("ops_drained", 64'(exp_q.size()), 64'(0));
    check("result_drained", 64'(res_q.size()), 64'(0));
    check("finish_alu_count", 64'(fa_aligned - fa0), 64'(exp_upd));
    check("stray_finish_alu", 64'(fa_abort - fab0), 64'(0));
    check("done_hold", 64'({halt, busy, finish_all, op_start}), 64'(4'b1000));
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic run_abort();
    int fa0;
    int fab0;
    int t_idle;
    fa0  = fa_aligned;
    fab0 = fa_abort;
    exp_q.delete();
    rs_stim.delete();
    for (int p = 0; p < 5; p++) exp_q.push_back(3'(p));
    for (int p = 0; p < 3; p++) exp_q.push_back(3'(p));
    rs_stim.push_back(32'h3F800000);
    abort_at = fire_idx + 7;
    launch(32'd64, 32'h3A83126F);
    t_idle = -1;
    for (int i = 0; i < BUDGET; i++) begin
      if (!busy) begin
        t_idle = cyc;
        break;
      end
      @(negedge clk);
    end
    check("abort_latency", 64'(t_idle), 64'(last_fire_cyc + 1));
    repeat (5) @(negedge clk);
    check("abort_counter", 64'(iteration_counter), 64'(1));
    check("abort_idle_flags", 64'({busy, halt, op_start, finish_all}), 64'(0));
    check("abort_ops_drained", 64'(exp_q.size()), 64'(0));
    check("abort_iter_finish_alu", 64'(fa_aligned - fa0), 64'(1));
    check("abort_finish_alu_pulse", 64'(fa_abort - fab0), 64'(1));
    abort_at = -1;
    exp_q.delete();
  endtask

  task automatic run_reset();
    for (int k = 0; k < MAX_IT; k++) plan[k] = 32'h3F800000;
    plan_solve(32'd128, 32'h3A83126F);
    lat_max = 3;
    launch(32'd128, 32'h3A83126F);
    @(negedge clk);
    check("pre_reset_busy", 64'({busy, op_start}), 64'(2'b10));
    #2 reset = 1'b0;
    #1 check("reset_clears", 64'({op_start, op_sel, num_blocks, busy, halt, finish_all, finish_alu,
                                   converged, len_error, iteration_counter}), 64'(0));
    @(negedge clk);
    exp_q.delete();
    res_q.delete();
    rs_stim.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 64'({op_start, busy, halt, iteration_counter}), 64'(0));
  endtask

  // Behavioural ALU: answers each launch after a random latency, checks launch timing.
  initial begin
    int cnt;
    bit pending;
    logic [2:0] psel;
    int exp_cyc;
    op_done = 1'b0;
    abort   = 1'b0;
    rs_new  = 32'd0;
    pending = 1'b0;
    cnt     = 0;
    psel    = 3'd0;
    forever begin
      @(negedge clk);
      op_done = 1'b0;
      abort   = 1'b0;
      if (!reset) pending = 1'b0;
      else begin
        if (pending) begin
          if (cnt == 0) begin
            pending = 1'b0;
            op_done = 1'b1;
            if (psel == 3'd3) begin
              rs_new = (rs_stim.size() > 0) ? rs_stim.pop_front() : 32'h3F800000;
              last_rr_cyc = cyc;
            end
            if (fire_idx == abort_at) abort = 1'b1;
            fire_idx++;
            last_fire_cyc = cyc;
            last_fire_sel = psel;
          end else cnt--;
        end
        if (op_start) begin
          exp_cyc = (start_cyc > last_fire_cyc) ? start_cyc + 1
                  : last_fire_cyc + ((last_fire_sel == 3'd3) ? 2 : 1);
          check("issue_latency", 64'(cyc), 64'(exp_cyc));
          pending = 1'b1;
          cnt     = $urandom_range(0, lat_max);
          psel    = op_sel;
          if (spurious && $urandom_range(0, 1) == 1) op_done = 1'b1;
        end else if (spurious && !busy && !halt && $urandom_range(0, 1) == 1) op_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches an op or finishes a solve.
  initial begin
    res_t r;
    int exp_fin;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (op_start) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_op_start: got launch of op_sel %0d, expected no launch", op_sel);
          end else check("op_sel", 64'(op_sel), 64'(exp_q.pop_front()));
          check("issue_flags", 64'({busy, halt}), 64'(2'b10));
        end
        if (finish_all) begin
          if (res_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_finish_all: got finish_all=1, expected 0");
          end else begin
            r = res_q.pop_front();
            check("result", 64'({converged, len_error, iteration_counter, num_blocks}), 64'(r));
            check("done_flags", 64'({halt, busy}), 64'(2'b10));
            exp_fin = r.len ? start_cyc + 1 : last_rr_cyc + 2;
            check("finish_timing", 64'(cyc), 64'(exp_fin));
          end
        end
        if (finish_alu) begin
          if (op_start && op_sel == 3'd0) fa_aligned++;
          else fa_abort++;
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    total     = 32'd0;
    tolerance = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'({op_start, op_sel, num_blocks, busy, halt, finish_all, finish_alu,
                             converged, len_error, iteration_counter}), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    lat_max = 1;
    plan = '{32'h3F800000, 32'h3C23D70A, 32'h38D1B717, 32'h3F800000};
    run_solve(32'd64, 32'h3A83126F, 1'b0);

    plan = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_solve(32'd64, 32'h3A83126F, 1'b0);

    run_solve(32'd7, 32'h3A83126F, 1'b0);

    plan = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run_solve(32'd8, 32'h3A83126F, 1'b0);

    plan = '{32'h3A83126F, 32'h3A83126F, 32'h3A83126E, 32'h3F800000};
    run_solve(32'd100, 32'h3A83126F, 1'b0);

    lat_max = 2;
    run_abort();

    spurious = 1'b1;
    plan = '{32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3F800000};
    run_solve(32'd200, 32'h3A83126F, 1'b1);
    run_solve(32'd5, 32'h3A83126F, 1'b1);
    spurious = 1'b0;

    run_reset();

    for (int n = 0; n < 12; n++) begin
      logic [31:0] r_tol;
      logic [31:0] r_tot;
      r_tol = 32'($urandom_range(32'h30000000, 32'h3F000000));
      r_tot = 32'($urandom_range(0, 200));
      for (int k = 0; k < MAX_IT; k++) begin
        case ($urandom_range(0, 3))
          0:       plan[k] = r_tol - 32'($urandom_range(1, 1000));
          1:       plan[k] = r_tol;
          2:       plan[k] = r_tol + 32'($urandom_range(1, 1000));
          default: plan[k] = 32'h3F800000 + 32'($urandom_range(0, 1000));
        endcase
      end
      lat_max  = $urandom_range(0, 3);
      spurious = 1'($urandom_range(0, 1));
      run_solve(r_tot, r_tol, 1'($urandom_range(0, 1)));
    end
    spurious = 1'b0;

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cg_iteration_sequencer.md
# cg_iteration_sequencer

Top-level phase scheduler for the conjugate-gradient datapath. Sequences one CG iteration as five operations on the shared 8-lane ALU (A·p mat-vec, p·Ap dot, x/r update, r·r dot, p update) with a single start/done handshake. After each r·r dot it checks convergence, counts iterations, and raises `halt`/`finish_all` when the solve ends. It sits between the host `start` and the ALU, memory-address control and result-write logic, which own the per-element addressing.

## Interface
Parameters:
- `no_of_units`, 8: ALU lanes; block count = `total/no_of_units`.
- `element_width`, 32: width of `rs_new` and `tolerance`.
- `iter_width`, 11: width of `iteration_counter`.
- `max_iterations`, 1024: iteration cap; must be ≤ 2^`iter_width`.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low.
- `start`, in, 1: solve request. Sampled only in IDLE.
- `abort`, in, 1: synchronous abort. Returns the block to IDLE.
- `total`, in, 32: vector length in elements. Sampled on start.
- `tolerance`, in, `element_width`: convergence threshold, IEEE-754 single, non-negative. Sampled on start.
- `rs_new`, in, `element_width`: r·r result, non-negative float. Valid with `op_done` of a DOT_RR op.
- `op_done`, in, 1: one-cycle pulse from the ALU marking the current op complete.
- `op_start`, out, 1: one-cycle op launch pulse.
- `op_sel`, out, 3: op code, held stable from issue until done. Codes: 0 MATVEC, 1 DOT_PAP, 2 UPD_XR, 3 DOT_RR, 4 UPD_P.
- `num_blocks`, out, 32: `total/no_of_units`, registered at start.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `halt`, out, 1: high in DONE.
- `finish_all`, out, 1: one-cycle pulse on entry to DONE.
- `finish_alu`, out, 1: one-cycle pulse at each iteration boundary. Downstream uses it to clear address counters.
- `converged`, out, 1: valid in DONE.
- `len_error`, out, 1: valid in DONE.
- `iteration_counter`, out, `iter_width`: completed iterations.

## Operation
- Reset values: all outputs 0; state IDLE.
- States: IDLE, ISSUE, WAIT, CHECK, DONE. A registered `phase` field (0–4) selects `op_sel`.
- IDLE:
  - On `start`, latch `total`, `tolerance`, compute `num_blocks`.
  - Clear `iteration_counter`, `converged`, `len_error`.
  - If `num_blocks`==0, go to DONE with `len_error`=1. Otherwise set phase=0 and go to ISSUE.
- ISSUE: `op_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: on `op_done`:
  - phase 0→1, 1→2, 2→3: advance phase and go to ISSUE.
  - phase 3: latch `rs_new` and go to CHECK.
  - phase 4: increment `iteration_counter`, pulse `finish_alu`, set phase=0, go to ISSUE.
- CHECK (one cycle):
  - If latched `rs_new` < `tolerance`, compare as unsigned bits (valid for non-negative IEEE floats). Set `converged`=1, increment `iteration_counter`, go to DONE.
  - Else if `iteration_counter`==`max_iterations`-1: increment the counter, go to DONE with `converged`=0.
  - Else set phase=4 and go to ISSUE.
- DONE:
  - `halt`=1; outputs hold.
  - `finish_all` pulses in the first DONE cycle only.
  - A new `start` behaves as in IDLE.
- `abort`:
  - Applies in any state except IDLE. Next state is IDLE, `busy`=0, `op_start` suppressed.
  - `iteration_counter` holds its value. `finish_alu` pulses once.
  - `abort` takes priority over a same-cycle `op_done`.
- `op_done` outside WAIT is ignored. `start` while busy is ignored.
- `iteration_counter` saturates at its maximum value and never wraps.
- Asserting `reset` mid-solve clears everything immediately (asynchronous).

## Timing
- `start` high at edge t → `op_start` high in cycle t+1 with `op_sel`=0.
- `op_done` at edge d → next `op_start` in cycle d+1. Minimum 2 cycles per op.
- DOT_RR done at d → CHECK in cycle d+1. Then either `op_start`(UPD_P) in cycle d+2, or DONE in cycle d+2 with `finish_all` in cycle d+2.
- Minimum iteration length is 11 cycles: 5 ops × 2 cycles + CHECK.
- `finish_alu` is registered and high in the cycle after the UPD_P `op_done`, coincident with the next MATVEC `op_start`.

## Test plan
- Basic convergence: total=64, tolerance=0x3A83126F (1e-3); ALU model returns `op_done` 3 cycles after each `op_start`; `rs_new`=0x3F800000, then 0x3C23D70A, then 0x38D1B717. Expect `op_sel` sequence 0,1,2,3,4 ×2 then 0,1,2,3; `converged`=1; `iteration_counter`=3; `num_blocks`=8; a single `finish_all` pulse.
- Iteration cap: `max_iterations`=4; `rs_new` always 0x3F800000. Expect DONE after the 4th CHECK with `iteration_counter`=4 and `converged`=0.
- Zero length: total=7. Expect DONE in the cycle after `start` with `len_error`=1, no `op_start`, `num_blocks`=0.
- Abort: raise `abort` in the same cycle as `op_done` during iteration 2, phase 2. Expect IDLE next cycle, no further `op_start`, `iteration_counter`=1, one `finish_alu` pulse.
- Handshake robustness: spurious `op_done` in ISSUE and IDLE, and `start` while busy. Expect no state change. Also apply an asynchronous `reset` mid-WAIT and expect all outputs 0 before the next clock edge.
